program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning address and PC width in bits (minimum 2).
REQ-002 SHALL have parameter STACK_DEPTH, default 4, meaning return-address stack entries (minimum 1).
REQ-003 SHALL have parameter RESET_ADDR, default 0, meaning PC value after reset (ADDR_W bits).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port stall, input, 1, hold all state this cycle.
REQ-008 SHALL have port op, input, 3, operation select: 000 INC, 001 JUMP, 010 BRREL, 011 CALL, 100 RET, 101 HALT, 110/111 reserved.
REQ-009 SHALL have port target, input, ADDR_W, absolute address for JUMP/CALL.
REQ-010 SHALL have port offset, input, ADDR_W, two's-complement displacement for BRREL.
REQ-011 SHALL have port pc, output, ADDR_W, current program counter (registered).
REQ-012 SHALL have port depth, output, $clog2(STACK_DEPTH+1), number of valid stack entries.
REQ-013 SHALL have port halted, output, 1, sequencer halted.
REQ-014 SHALL have port err_ovf, output, 1, sticky: CALL attempted with stack full.
REQ-015 SHALL have port err_unf, output, 1, sticky: RET attempted with stack empty.

Function
REQ-016 SHALL evaluate once per rising clk edge with priority: reset > halted > stall > op.
REQ-017 INC SHALL set pc to pc+1 modulo 2^ADDR_W (all-ones wraps to 0).
REQ-018 JUMP SHALL set pc to target.
REQ-019 BRREL SHALL set pc to pc+offset modulo 2^ADDR_W, with offset sign-extended (0xFF = -1 at ADDR_W=8).
REQ-020 CALL with depth < STACK_DEPTH SHALL push (pc+1) modulo 2^ADDR_W, increment depth and set pc to target, all in the same edge.
REQ-021 CALL with depth == STACK_DEPTH SHALL leave pc, stack and depth unchanged and set err_ovf.
REQ-022 RET with depth > 0 SHALL set pc to the top entry and decrement depth (LIFO).
REQ-023 RET with depth == 0 SHALL leave pc unchanged and set err_unf.
REQ-024 HALT SHALL leave pc unchanged and set halted; halted is cleared only by reset.
REQ-025 Reserved op codes SHALL behave as INC.
REQ-026 While halted == 1, all op and stall inputs SHALL be ignored; pc, stack and depth SHALL hold.
REQ-027 stall == 1 SHALL hold pc, stack, depth, halted and error flags regardless of op.
REQ-028 err_ovf and err_unf SHALL remain set until reset; later successful ops SHALL NOT clear them.
REQ-029 All outputs SHALL be registered; an op presented before edge N SHALL be visible on pc/depth after edge N (1-cycle latency).
REQ-030 Stack entries beyond depth SHALL NOT affect any output.

Reset
REQ-031 Asserting reset SHALL immediately, without a clock edge, set pc=RESET_ADDR, depth=0, halted=0, err_ovf=0, err_unf=0.
REQ-032 Reset asserted mid-sequence (e.g. with stack partially full or halted) SHALL discard all stack contents and produce the same values as REQ-031.
REQ-033 The first edge after reset deassertion SHALL execute the op presented then.

Verification
REQ-034 Defaults; reset, then 300 INC cycles -> pc counts 0x00..0xFF, wraps to 0x00 at cycle 256, reaches 0x2C at cycle 300.
REQ-035 pc=0x10: CALL target=0x40, CALL target=0x80, RET, RET -> pc 0x40, 0x80, 0x41, 0x11; depth 1, 2, 1, 0.
REQ-036 Five CALLs from pc=0x00 (targets 0x10,0x20,0x30,0x40,0x50) -> depth=4, 5th CALL leaves pc=0x40, err_ovf=1; then four RETs -> pc 0x31, 0x21, 0x11, 0x01, err_ovf still 1.
REQ-037 Reset, RET -> pc=0x00, err_unf=1, depth=0; BRREL offset=0xFE from pc=0x05 -> pc=0x03; BRREL offset=0x10 from pc=0xF8 -> pc=0x08.
REQ-038 stall=1 with op=JUMP target=0x99 for 3 cycles -> pc unchanged; HALT -> halted=1; subsequent JUMP ignored; reset asserted between edges -> pc=0x00, halted=0 before next edge.
REQ-039 Parameter variant ADDR_W=4, STACK_DEPTH=1, RESET_ADDR=0xA: reset -> pc=0xA; INC x6 -> pc=0x0; CALL target 0x5 then CALL -> err_ovf=1, pc=0x5.

Source files
------------

// File: rtl/program_sequencer.sv
// Program counter sequencer with a LIFO return-address stack, halt state and
// sticky overflow/underflow flags. Priority each edge: reset > halted > stall > op.
module program_sequencer #(
  parameter int                ADDR_W      = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               stall,
  input  logic [2:0]                         op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [ADDR_W-1:0]                  offset,
  output logic [ADDR_W-1:0]                  pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               halted,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int            DW   = $clog2(STACK_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  typedef enum logic [2:0] {
    OP_INC   = 3'b000,
    OP_JUMP  = 3'b001,
    OP_BRREL = 3'b010,
    OP_CALL  = 3'b011,
    OP_RET   = 3'b100,
    OP_HALT  = 3'b101
  } op_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DW-1:0]     depth_q, depth_d;
  logic              halted_q, halted_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] top_entry;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  assign pc_inc = pc_q + ADDR_W'(1);

  // Only the entry just below depth is visible; stale entries above it are never selected.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top_entry = stack_q[i];
    end
  end

  always_comb begin
    pc_d     = pc_q;
    depth_d  = depth_q;
    halted_d = halted_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_en  = 1'b0;
    if (!halted_q && !stall) begin
      case (op)
        OP_JUMP:  pc_d = target;
        OP_BRREL: pc_d = pc_q + offset;
        OP_CALL: begin
          if (depth_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            push_en = 1'b1;
            depth_d = depth_q + DW'(1);
            pc_d    = target;
          end
        end
        OP_RET: begin
          if (depth_q == '0) begin
            unf_d = 1'b1;
          end else begin
            pc_d    = top_entry;
            depth_d = depth_q - DW'(1);
          end
        end
        OP_HALT:  halted_d = 1'b1;
        default:  pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_ADDR;
      depth_q  <= '0;
      halted_q <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      depth_q  <= depth_d;
      halted_q <= halted_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (push_en && depth_q == DW'(i)) stack_q[i] <= pc_inc;
      end
    end
  end

  assign pc      = pc_q;
  assign depth   = depth_q;
  assign halted  = halted_q;
  assign err_ovf = ovf_q;
  assign err_unf = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer: default instance plus a small
// ADDR_W=4 / STACK_DEPTH=1 / RESET_ADDR=0xA instance.
module tb_program_sequencer;

  localparam logic [2:0] INC = 3'b000, JUMP = 3'b001, BRREL = 3'b010,
                         CALL = 3'b011, RET = 3'b100, HALT = 3'b101;

  logic       clk;
  logic       reset, stall;
  logic [2:0] op;
  logic [7:0] target, offset;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       halted, err_ovf, err_unf;

  logic       reset2, stall2;
  logic [2:0] op2;
  logic [3:0] target2, offset2;
  logic [3:0] pc2;
  logic [0:0] depth2;
  logic       halted2, err_ovf2, err_unf2;

  int checks = 0;
  int errors = 0;

  logic [13:0] obs, exp;
  logic [7:0]  obs2, exp2;

  program_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .op(op), .target(target), .offset(offset),
    .pc(pc), .depth(depth), .halted(halted), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  program_sequencer #(.ADDR_W(4), .STACK_DEPTH(1), .RESET_ADDR(4'hA)) dutSmall (
    .clk(clk), .reset(reset2), .stall(stall2), .op(op2), .target(target2), .offset(offset2),
    .pc(pc2), .depth(depth2), .halted(halted2), .err_ovf(err_ovf2), .err_unf(err_unf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one op, let one edge execute it, then settle before sampling.
  task automatic applyStimulus(input logic [2:0] o, input logic [7:0] t, input logic [7:0] f);
    op = o; target = t; offset = f;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusSmall(input logic [2:0] o, input logic [3:0] t);
    op2 = o; target2 = t; offset2 = 4'h0;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1; stall = 1'b0; op = INC;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    applyStimulus(JUMP, 8'h33, 8'h00);
    applyStimulus(CALL, 8'h44, 8'h00);
    reset = 1'b1;
    #1;
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h00, 3'd0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL reset_async: got %h expected %h", obs, exp);
    end
    reset = 1'b0;
    applyStimulus(JUMP, 8'h5A, 8'h00);
    checks++;
    if (pc !== 8'h5A) begin
      errors++; $display("[TB] FAIL first_edge_after_reset: got %h expected %h", pc, 8'h5A);
    end
  endtask

  task automatic test_inc_wrap();
    resetDut();
    for (int k = 1; k <= 300; k++) begin
      applyStimulus(INC, 8'h00, 8'h00);
      obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'(k % 256), 3'd0, 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL inc_cycle_%0d: got %h expected %h", k, obs, exp);
      end
    end
  endtask

  task automatic test_call_ret();
    logic [2:0] ops [4] = '{CALL, CALL, RET, RET};
    logic [7:0] tgs [4] = '{8'h40, 8'h80, 8'h00, 8'h00};
    logic [7:0] pcs [4] = '{8'h40, 8'h80, 8'h41, 8'h11};
    logic [2:0] dps [4] = '{3'd1, 3'd2, 3'd1, 3'd0};
    resetDut();
    applyStimulus(JUMP, 8'h10, 8'h00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ops[i], tgs[i], 8'h00);
      obs = {pc, depth, halted, err_ovf, err_unf}; exp = {pcs[i], dps[i], 3'b000};
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL call_ret_step%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] pcs [9] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h40, 8'h31, 8'h21, 8'h11, 8'h01};
    logic [2:0] dps [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    logic       ovf [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    resetDut();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) applyStimulus(CALL, 8'((i + 1) * 16), 8'h00);
      else       applyStimulus(RET, 8'h00, 8'h00);
      obs = {pc, depth, halted, err_ovf, err_unf}; exp = {pcs[i], dps[i], 1'b0, ovf[i], 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++; $display("[TB] FAIL overflow_step%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_underflow_brrel();
    resetDut();
    applyStimulus(RET, 8'h00, 8'h00);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h00, 3'd0, 3'b001};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL underflow: got %h expected %h", obs, exp);
    end
    applyStimulus(JUMP, 8'h05, 8'h00);
    applyStimulus(BRREL, 8'h00, 8'hFE);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h03, 3'd0, 3'b001};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL brrel_negative: got %h expected %h", obs, exp);
    end
    applyStimulus(JUMP, 8'hF8, 8'h00);
    applyStimulus(BRREL, 8'h00, 8'h10);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h08, 3'd0, 3'b001};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL brrel_wrap: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_reserved();
    resetDut();
    applyStimulus(3'b110, 8'h77, 8'h00);
    applyStimulus(3'b111, 8'h77, 8'h00);
    checks++;
    if (pc !== 8'h02) begin
      errors++; $display("[TB] FAIL reserved_as_inc: got %h expected %h", pc, 8'h02);
    end
  endtask

  task automatic test_stall_halt();
    resetDut();
    applyStimulus(JUMP, 8'h20, 8'h00);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(JUMP, 8'h99, 8'h00);
      checks++;
      if (pc !== 8'h20) begin
        errors++; $display("[TB] FAIL stall_jump%0d: got %h expected %h", i, pc, 8'h20);
      end
    end
    applyStimulus(CALL, 8'h99, 8'h00);
    applyStimulus(RET, 8'h00, 8'h00);
    applyStimulus(HALT, 8'h00, 8'h00);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h20, 3'd0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL stall_holds_all: got %h expected %h", obs, exp);
    end
    stall = 1'b0;
    applyStimulus(CALL, 8'h60, 8'h00);
    applyStimulus(HALT, 8'h00, 8'h00);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h60, 3'd1, 3'b100};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL halt: got %h expected %h", obs, exp);
    end
    applyStimulus(JUMP, 8'h99, 8'h00);
    applyStimulus(RET, 8'h00, 8'h00);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h60, 3'd1, 3'b100};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL halted_ignores_ops: got %h expected %h", obs, exp);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h00, 3'd0, 3'b000};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL reset_while_halted: got %h expected %h", obs, exp);
    end
    reset = 1'b0;
    applyStimulus(RET, 8'h00, 8'h00);
    obs = {pc, depth, halted, err_ovf, err_unf}; exp = {8'h00, 3'd0, 3'b001};
    checks++;
    if (obs !== exp) begin
      errors++; $display("[TB] FAIL stack_discarded: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_param_variant();
    reset2 = 1'b1;
    #1;
    obs2 = {pc2, depth2, halted2, err_ovf2, err_unf2}; exp2 = {4'hA, 1'b0, 3'b000};
    checks++;
    if (obs2 !== exp2) begin
      errors++; $display("[TB] FAIL small_reset: got %h expected %h", obs2, exp2);
    end
    reset2 = 1'b0;
    for (int i = 0; i < 6; i++) applyStimulusSmall(INC, 4'h0);
    checks++;
    if (pc2 !== 4'h0) begin
      errors++; $display("[TB] FAIL small_inc_wrap: got %h expected %h", pc2, 4'h0);
    end
    applyStimulusSmall(CALL, 4'h5);
    applyStimulusSmall(CALL, 4'h9);
    obs2 = {pc2, depth2, halted2, err_ovf2, err_unf2}; exp2 = {4'h5, 1'b1, 3'b010};
    checks++;
    if (obs2 !== exp2) begin
      errors++; $display("[TB] FAIL small_overflow: got %h expected %h", obs2, exp2);
    end
    applyStimulusSmall(RET, 4'h0);
    obs2 = {pc2, depth2, halted2, err_ovf2, err_unf2}; exp2 = {4'h1, 1'b0, 3'b010};
    checks++;
    if (obs2 !== exp2) begin
      errors++; $display("[TB] FAIL small_ret: got %h expected %h", obs2, exp2);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; op = INC; target = '0; offset = '0;
    reset2 = 1'b1; stall2 = 1'b0; op2 = INC; target2 = '0; offset2 = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    reset2 = 1'b0;
    test_reset();
    test_inc_wrap();
    test_call_ret();
    test_overflow();
    test_underflow_brrel();
    test_reserved();
    test_stall_halt();
    test_param_variant();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
